// File: rtl/spi_param_pkg.sv
// Shared constants, state encoding and default widths for the SPI parameter responder.
package spi_param_pkg;

  localparam logic [7:0]  CMD_WRITE  = 8'h01;
  localparam logic [7:0]  CMD_READ   = 8'h02;
  localparam int unsigned WORD_BITS  = 40;
  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 36;
  localparam int unsigned CNT_W      = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/spi_param_responder_sync_edge.sv
// sync_edge: 2-FF synchronizer plus edge-detect register with rise/fall pulses.
// Edges are suppressed until the pipeline has refilled after reset, so a line
// that is already away from its idle level does not fake an edge.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_c_o,
  output logic fall_c_o
);

  logic       s1_q, s2_q, s3_q;
  logic [2:0] vld_q;

  // Synchronizer chain, edge history and post-reset fill tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= RST_VAL;
      s2_q  <= RST_VAL;
      s3_q  <= RST_VAL;
      vld_q <= 3'b000;
    end else begin
      s1_q  <= d_i;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      vld_q <= {vld_q[1:0], 1'b1};
    end
  end

  assign rise_c_o = vld_q[2] &  s2_q & ~s3_q;
  assign fall_c_o = vld_q[2] & ~s2_q &  s3_q;

endmodule

// File: rtl/spi_param_responder.sv
// spi_param_responder: SPI mode-0 target turning host transactions into
// parameter-memory write/read strobes. Define SPI_READBACK_EN to build the
// READ command, prefetch logic and MISO output shifter.
module spi_param_responder
  import spi_param_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic [ADDR_W-1:0] param_addr,
  output logic [DATA_W-1:0] param_wdata,
  output logic              param_we,
  output logic              param_re,
  input  logic [DATA_W-1:0] param_rdata,
  output logic              active,
  output logic              cmd_error
);

  localparam int unsigned SR_W = DATA_W - 1;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic mosi_s1_q, mosi_s2_q;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic                active_q, active_d;

  logic [7:0]          cmd_byte;
  logic [ADDR_W-1:0]   addr_word;
  logic [DATA_W-1:0]   data_word;

`ifdef SPI_READBACK_EN
  logic                 rd_q, rd_d;
  logic                 re_q, re_d;
  logic                 re_dly_q;
  logic [WORD_BITS-1:0] shift_q, shift_d;
  logic                 miso_q, miso_d;
`endif

  sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk      (clk),
    .rst      (rst),
    .d_i      (sclk),
    .rise_c_o (sclk_rise),
    .fall_c_o (sclk_fall)
  );

  sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk      (clk),
    .rst      (rst),
    .d_i      (cs_n),
    .rise_c_o (cs_rise),
    .fall_c_o (cs_fall)
  );

  // Plain 2-FF synchronizer for MOSI, aligned with the SCLK edge pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      mosi_s1_q <= mosi;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  assign cmd_byte  = {sr_q[6:0], mosi_s2_q};
  assign addr_word = {sr_q[ADDR_W-2:0], mosi_s2_q};
  assign data_word = {sr_q[DATA_W-2:0], mosi_s2_q};

  // Next-state logic: framing, command decode, address/data capture and strobes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    err_d    = 1'b0;
    active_d = active_q;
`ifdef SPI_READBACK_EN
    rd_d     = rd_q;
    re_d     = 1'b0;
    shift_d  = shift_q;
    miso_d   = miso_q;
    if (re_dly_q) begin
      shift_d = WORD_BITS'(param_rdata);
    end else if (sclk_fall && (state_q == ST_DATA) && rd_q) begin
      miso_d  = shift_q[WORD_BITS-1];
      shift_d = {shift_q[WORD_BITS-2:0], 1'b0};
    end
`endif
    // Post-increment after the write strobe cycle.
    if (we_q) addr_d = addr_q + ADDR_W'(1);

    if (cs_rise) begin
      // A word whose last bit lands with CS rise still completes.
      if ((state_q == ST_DATA) && sclk_rise && (cnt_q == CNT_W'(WORD_BITS - 1))) begin
`ifdef SPI_READBACK_EN
        if (!rd_q)
`endif
        begin
          wdata_d = data_word;
          we_d    = 1'b1;
        end
      end
      state_d  = ST_IDLE;
      cnt_d    = '0;
      active_d = 1'b0;
`ifdef SPI_READBACK_EN
      miso_d   = 1'b0;
`endif
    end else if (cs_fall) begin
      state_d  = ST_CMD;
      cnt_d    = '0;
      active_d = 1'b1;
`ifdef SPI_READBACK_EN
      rd_d     = 1'b0;
      miso_d   = 1'b0;
`endif
    end else if (sclk_rise) begin
      sr_d  = {sr_q[SR_W-2:0], mosi_s2_q};
      cnt_d = cnt_q + CNT_W'(1);
      case (state_q)
        ST_CMD: begin
          if (cnt_q == CNT_W'(7)) begin
            cnt_d = '0;
            if (cmd_byte == CMD_WRITE) begin
              state_d = ST_ADDR;
`ifdef SPI_READBACK_EN
            end else if (cmd_byte == CMD_READ) begin
              state_d = ST_ADDR;
              rd_d    = 1'b1;
`endif
            end else begin
              state_d = ST_IGNORE;
              err_d   = 1'b1;
            end
          end
        end
        ST_ADDR: begin
          if (cnt_q == CNT_W'(ADDR_W - 1)) begin
            cnt_d   = '0;
            addr_d  = addr_word;
            state_d = ST_DATA;
`ifdef SPI_READBACK_EN
            re_d    = rd_q;
`endif
          end
        end
        ST_DATA: begin
          if (cnt_q == CNT_W'(WORD_BITS - 1)) begin
            cnt_d = '0;
`ifdef SPI_READBACK_EN
            if (rd_q) begin
              addr_d = addr_q + ADDR_W'(1);
              re_d   = 1'b1;
            end else
`endif
            begin
              wdata_d = data_word;
              we_d    = 1'b1;
            end
          end
        end
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sr_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      err_q    <= err_d;
      active_q <= active_d;
    end
  end

`ifdef SPI_READBACK_EN
  // Readback registers: command kind, read strobe, data-return delay, shifter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q     <= 1'b0;
      re_q     <= 1'b0;
      re_dly_q <= 1'b0;
      shift_q  <= '0;
      miso_q   <= 1'b0;
    end else begin
      rd_q     <= rd_d;
      re_q     <= re_d;
      re_dly_q <= re_q;
      shift_q  <= shift_d;
      miso_q   <= miso_d;
    end
  end

  assign param_re = re_q;
  assign miso     = miso_q;
`else
  logic unused_readback;
  assign unused_readback = ^{param_rdata, sclk_fall};
  assign param_re = 1'b0;
  assign miso     = 1'b0;
`endif

  assign param_addr  = addr_q;
  assign param_wdata = wdata_q;
  assign param_we    = we_q;
  assign active      = active_q;
  assign cmd_error   = err_q;

endmodule
